cond_logic: RTL and testbench

COND_LOGIC -- requirements
Module: cond_logic

---
 rtl/cond_logic.sv | 93 +++++++++
 tb/tb_cond_logic.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cond_logic.sv
// Conditional-execution unit: evaluates the condition field against registered {N,Z,C,V}
// flags, gates the decoder's write strobes and counts executed and squashed instructions.
module cond_logic (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [3:0]  Cond,
  input  logic [3:0]  ALUFlags,
  input  logic [1:0]  FlagW,
  input  logic        PCS,
  input  logic        RegW,
  input  logic        MemW,
  output logic        PCSrc,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic        CondEx,
  output logic [3:0]  Flags,
  output logic [15:0] ExecCnt,
  output logic [15:0] SkipCnt
);

  localparam logic [15:0] CntMax = 16'hFFFF;

  logic [3:0]  flags_q, flags_d;
  logic [15:0] exec_q, exec_d;
  logic [15:0] skip_q, skip_d;
  logic        flag_n, flag_z, flag_c, flag_v;
  logic        cond_ex;
  logic        go;

  assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

  // Evaluated on the registered flags only, so a flag-setting instruction sees the old flags.
  always_comb begin
    cond_ex = 1'b0;
    unique case (Cond)
      4'b0000: cond_ex = flag_z;
      4'b0001: cond_ex = ~flag_z;
      4'b0010: cond_ex = flag_c;
      4'b0011: cond_ex = ~flag_c;
      4'b0100: cond_ex = flag_n;
      4'b0101: cond_ex = ~flag_n;
      4'b0110: cond_ex = flag_v;
      4'b0111: cond_ex = ~flag_v;
      4'b1000: cond_ex = flag_c & ~flag_z;
      4'b1001: cond_ex = ~flag_c | flag_z;
      4'b1010: cond_ex = (flag_n == flag_v);
      4'b1011: cond_ex = (flag_n != flag_v);
      4'b1100: cond_ex = ~flag_z & (flag_n == flag_v);
      4'b1101: cond_ex = flag_z | (flag_n != flag_v);
      4'b1110: cond_ex = 1'b1;
      4'b1111: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  assign go = en & reset & cond_ex;

  assign CondEx   = cond_ex;
  assign PCSrc    = PCS & go;
  assign RegWrite = RegW & go;
  assign MemWrite = MemW & go;
  assign Flags    = flags_q;
  assign ExecCnt  = exec_q;
  assign SkipCnt  = skip_q;

  always_comb begin
    flags_d = flags_q;
    exec_d  = exec_q;
    skip_d  = skip_q;
    if (!reset) begin
      flags_d = 4'b0000;
      exec_d  = 16'h0000;
      skip_d  = 16'h0000;
    end else if (en) begin
      if (go && FlagW[1]) flags_d[3:2] = ALUFlags[3:2];
      if (go && FlagW[0]) flags_d[1:0] = ALUFlags[1:0];
      // Exactly one counter advances per enabled cycle; both stick at all-ones.
      if (cond_ex) begin
        if (exec_q != CntMax) exec_d = exec_q + 16'd1;
      end else begin
        if (skip_q != CntMax) skip_d = skip_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    flags_q <= flags_d;
    exec_q  <= exec_d;
    skip_q  <= skip_d;
  end

endmodule

// File: tb/tb_cond_logic.sv
// Self-checking bench for cond_logic: directed scenarios plus randomized traffic
// compared against a flag/counter reference model.
module tb_cond_logic;

  logic        clk = 1'b0;
  logic        reset, en, PCS, RegW, MemW;
  logic [3:0]  Cond, ALUFlags;
  logic [1:0]  FlagW;
  logic        PCSrc, RegWrite, MemWrite, CondEx;
  logic [3:0]  Flags;
  logic [15:0] ExecCnt, SkipCnt;

  int checks = 0;
  int errors = 0;

  // Reference state
  logic [3:0] m_flags = 4'b0000;
  int         m_exec  = 0;
  int         m_skip  = 0;

  cond_logic dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .Cond     (Cond),
    .ALUFlags (ALUFlags),
    .FlagW    (FlagW),
    .PCS      (PCS),
    .RegW     (RegW),
    .MemW     (MemW),
    .PCSrc    (PCSrc),
    .RegWrite (RegWrite),
    .MemWrite (MemWrite),
    .CondEx   (CondEx),
    .Flags    (Flags),
    .ExecCnt  (ExecCnt),
    .SkipCnt  (SkipCnt)
  );

  always #5 clk = ~clk;

  // Odd codes are the negation of the even code below them; 111x always passes.
  function automatic logic model_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: return 1'b1;
    endcase
    return base ^ c[0];
  endfunction

  function automatic logic model_go();
    return en && reset && model_cond(Cond, m_flags);
  endfunction

  // Advance the model by one clock edge using the currently driven inputs.
  function automatic void model_edge();
    logic ok;
    ok = model_cond(Cond, m_flags);
    if (!reset) begin
      m_flags = 4'b0000;
      m_exec  = 0;
      m_skip  = 0;
    end else if (en) begin
      if (ok && FlagW[1]) m_flags[3:2] = ALUFlags[3:2];
      if (ok && FlagW[0]) m_flags[1:0] = ALUFlags[1:0];
      if (ok) m_exec = (m_exec < 65535) ? m_exec + 1 : 65535;
      else    m_skip = (m_skip < 65535) ? m_skip + 1 : 65535;
    end
  endfunction

  task automatic apply(input logic r, input logic e, input logic [3:0] c, input logic [3:0] alu,
                       input logic [1:0] fw, input logic pcs, input logic rw, input logic mw);
    reset = r; en = e; Cond = c; ALUFlags = alu; FlagW = fw; PCS = pcs; RegW = rw; MemW = mw;
    #2;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply(1'b0, 1'b1, 4'b1110, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1);
    tick();
    checks++;
    if (RegWrite !== 1'b0 || PCSrc !== 1'b0 || MemWrite !== 1'b0) begin
      errors++;
      $display("FAIL reset_strobes: got %b%b%b want 000", PCSrc, RegWrite, MemWrite);
    end
    tick();
    checks++;
    if (Flags !== 4'b0000 || ExecCnt !== 16'h0 || SkipCnt !== 16'h0) begin
      errors++;
      $display("FAIL reset_state: got flags=%b exec=%h skip=%h want 0000/0/0", Flags, ExecCnt,
               SkipCnt);
    end
    apply(1'b1, 1'b1, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0);
    checks++;
    if (CondEx !== 1'b0 || RegWrite !== 1'b0) begin
      errors++;
      $display("FAIL eq_after_reset: got condex=%b regwrite=%b want 0 0", CondEx, RegWrite);
    end
    tick();
    checks++;
    if (SkipCnt !== 16'd1 || Flags !== 4'b0000 || ExecCnt !== 16'd0) begin
      errors++;
      $display("FAIL first_skip: got skip=%0d exec=%0d flags=%b want 1 0 0000", SkipCnt, ExecCnt,
               Flags);
    end
    apply(1'b1, 1'b1, 4'b0001, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0);
    checks++;
    if (CondEx !== 1'b1) begin
      errors++;
      $display("FAIL ne_after_reset: got %b want 1", CondEx);
    end
  endtask

  task automatic test_flag_set();
    int exec0;
    apply(1'b1, 1'b1, 4'b1110, 4'b0100, 2'b11, 1'b0, 1'b0, 1'b0);
    tick();
    checks++;
    if (Flags !== 4'b0100) begin
      errors++;
      $display("FAIL al_flag_set: got %b want 0100", Flags);
    end
    exec0 = m_exec;
    apply(1'b1, 1'b1, 4'b0000, 4'b1111, 2'b00, 1'b1, 1'b0, 1'b0);
    checks++;
    if (CondEx !== 1'b1 || PCSrc !== 1'b1) begin
      errors++;
      $display("FAIL eq_pcsrc: got condex=%b pcsrc=%b want 1 1", CondEx, PCSrc);
    end
    tick();
    checks++;
    if (int'(ExecCnt) !== exec0 + 1 || Flags !== 4'b0100) begin
      errors++;
      $display("FAIL eq_exec: got exec=%0d flags=%b want %0d 0100", ExecCnt, Flags, exec0 + 1);
    end
  endtask

  task automatic test_lt_ge();
    apply(1'b1, 1'b1, 4'b1110, 4'b1000, 2'b11, 1'b0, 1'b0, 1'b0);
    tick();
    apply(1'b1, 1'b1, 4'b1011, 4'b0011, 2'b01, 1'b0, 1'b0, 1'b0);
    checks++;
    if (CondEx !== 1'b1) begin
      errors++;
      $display("FAIL lt_condex: got %b want 1", CondEx);
    end
    tick();
    checks++;
    if (Flags !== 4'b1011) begin
      errors++;
      $display("FAIL lt_flags_cv_only: got %b want 1011", Flags);
    end
    apply(1'b1, 1'b1, 4'b1010, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0);
    checks++;
    if (CondEx !== 1'b1) begin
      errors++;
      $display("FAIL ge_condex: got %b want 1", CondEx);
    end
    tick();
  endtask

  task automatic test_squash();
    int skip0;
    apply(1'b1, 1'b1, 4'b1110, 4'b0100, 2'b11, 1'b0, 1'b0, 1'b0);
    tick();
    skip0 = m_skip;
    apply(1'b1, 1'b1, 4'b0001, 4'b0000, 2'b11, 1'b0, 1'b0, 1'b1);
    checks++;
    if (MemWrite !== 1'b0 || CondEx !== 1'b0) begin
      errors++;
      $display("FAIL ne_squash: got memwrite=%b condex=%b want 0 0", MemWrite, CondEx);
    end
    tick();
    checks++;
    if (Flags !== 4'b0100 || int'(SkipCnt) !== skip0 + 1) begin
      errors++;
      $display("FAIL squash_hold: got flags=%b skip=%0d want 0100 %0d", Flags, SkipCnt,
               skip0 + 1);
    end
  endtask

  task automatic test_stall();
    logic [3:0] f0;
    int e0, s0;
    f0 = m_flags; e0 = m_exec; s0 = m_skip;
    apply(1'b1, 1'b0, 4'b1110, 4'b1011, 2'b11, 1'b1, 1'b1, 1'b1);
    checks++;
    if (RegWrite !== 1'b0 || PCSrc !== 1'b0 || MemWrite !== 1'b0) begin
      errors++;
      $display("FAIL stall_strobes: got %b%b%b want 000", PCSrc, RegWrite, MemWrite);
    end
    tick();
    tick();
    checks++;
    if (Flags !== f0 || int'(ExecCnt) !== e0 || int'(SkipCnt) !== s0) begin
      errors++;
      $display("FAIL stall_hold: got %b/%0d/%0d want %b/%0d/%0d", Flags, ExecCnt, SkipCnt, f0, e0,
               s0);
    end
  endtask

  task automatic test_saturation();
    apply(1'b0, 1'b1, 4'b1110, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0);
    tick();
    apply(1'b1, 1'b1, 4'b1110, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 65534; i++) tick();
    checks++;
    if (ExecCnt !== 16'hFFFE) begin
      errors++;
      $display("FAIL exec_preload: got %h want fffe", ExecCnt);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (ExecCnt !== 16'hFFFF || SkipCnt !== 16'h0) begin
        errors++;
        $display("FAIL exec_saturate[%0d]: got exec=%h skip=%h want ffff 0000", i, ExecCnt,
                 SkipCnt);
      end
    end
    apply(1'b0, 1'b1, 4'b1110, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1);
    checks++;
    if (PCSrc !== 1'b0 || RegWrite !== 1'b0 || MemWrite !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset_strobes: got %b%b%b want 000", PCSrc, RegWrite, MemWrite);
    end
    tick();
    checks++;
    if (Flags !== 4'b0000 || ExecCnt !== 16'h0 || SkipCnt !== 16'h0) begin
      errors++;
      $display("FAIL midrun_reset: got flags=%b exec=%h skip=%h want 0000 0 0", Flags, ExecCnt,
               SkipCnt);
    end
  endtask

  task automatic test_random();
    logic r, e;
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(15) != 0);
      e = ($urandom_range(3) != 0);
      apply(r, e, 4'($urandom), 4'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom));
      checks++;
      if (CondEx !== model_cond(Cond, m_flags) || PCSrc !== (PCS && model_go()) ||
          RegWrite !== (RegW && model_go()) || MemWrite !== (MemW && model_go())) begin
        errors++;
        $display("FAIL rand_comb[%0d]: got cx=%b p=%b r=%b m=%b cond=%h flags=%b", i, CondEx,
                 PCSrc, RegWrite, MemWrite, Cond, m_flags);
      end
      tick();
      checks++;
      if (Flags !== m_flags || int'(ExecCnt) !== m_exec || int'(SkipCnt) !== m_skip) begin
        errors++;
        $display("FAIL rand_state[%0d]: got %b/%0d/%0d want %b/%0d/%0d", i, Flags, ExecCnt,
                 SkipCnt, m_flags, m_exec, m_skip);
      end
    end
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; Cond = 4'h0; ALUFlags = 4'h0; FlagW = 2'b00;
    PCS = 1'b0; RegW = 1'b0; MemW = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_flag_set();
    test_lt_ge();
    test_squash();
    test_stall();
    test_random();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
